regfile_wb_sched: RTL and testbench
===================================

Name: regfile_wb_sched

Overview:
- Schedules the single write port of the 32x32 integer register file between two producers: the in-order pipeline writeback (WB) and the multi-cycle multiply/divide unit (MDU).
- Keeps a 32-entry scoreboard of destination registers with an MDU result outstanding, and raises an issue stall on RAW/WAW hazards against them.
- Sits between the WB stage, the MDU result port and the register file write inputs (reg_write, wb_rd_addr, back_rd_data).

Parameters:
- STARVE_MAX, 4, consecutive cycles a valid MDU result may lose arbitration before it is forced through (guard feature only).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pipe_wb_valid  in  1  WB stage has a result
- pipe_wb_ready  out  1  WB result accepted this cycle
- pipe_wb_rd  in  5  WB destination
- pipe_wb_data  in  XLEN  WB result
- mdu_valid  in  1  MDU result available
- mdu_ready  out  1  MDU result accepted this cycle
- mdu_rd  in  5  MDU destination
- mdu_data  in  XLEN  MDU result
- issue_valid  in  1  instruction in decode wants to issue
- issue_long  in  1  issuing instruction targets the MDU
- issue_rs1, issue_rs2, issue_rd  in  5 each  decode operand/destination addresses
- issue_stall  out  1  hazard; decode must hold
- reg_write  out  1  register file write enable
- wb_rd_addr  out  5  register file write address
- back_rd_data  out  XLEN  register file write data

Behaviour:
- Reset: all outputs 0, scoreboard all clear, starve counter 0, state ARB_NORMAL. A reset in mid-operation discards any accepted-but-unwritten result.
- Write port outputs are registered. An accepted result appears on reg_write/wb_rd_addr/back_rd_data exactly 1 cycle after acceptance.
- A destination of x0 still completes the handshake but drives reg_write=0.
- Arbitration in state ARB_NORMAL:
  - WB has fixed priority: pipe_wb_ready=1.
  - mdu_ready = !pipe_wb_valid.
  - At most one acceptance per cycle.
- Handshakes are valid/ready. Producers hold valid and payload stable until ready.
- Scoreboard set: on issue_valid && issue_long && !issue_stall && issue_rd!=0, set pending[issue_rd].
- Scoreboard clear: on MDU acceptance, clear pending[mdu_rd].
- Same-register set and clear in the same cycle: the set wins.
- Stall rule: issue_stall = issue_valid && (pending[rs1] || pending[rs2] || pending[rd]). The check is combinational, and x0 is never pending.
- A write of the same rd by WB while that rd is pending cannot occur, because the WAW stall prevents it. Verification asserts this.
- An MDU result for an rd not pending is a protocol error (assertion only). It is written normally.

Optional Feature:
- Macro: WB_STARVE_GUARD_EN.
- With the macro:
  - The starve counter increments each cycle mdu_valid && !mdu_ready, and resets to 0 on MDU acceptance.
  - When the count reaches STARVE_MAX, the state goes ARB_NORMAL -> ARB_MDU_FORCE.
  - In ARB_MDU_FORCE: mdu_ready=1 and pipe_wb_ready=0.
  - After the MDU acceptance the state returns to ARB_NORMAL.
- Without the macro: there is no counter and no ARB_MDU_FORCE state, WB always wins, and MDU progress depends on WB bubbles.

Decomposition:
- Shared core package holds:
  - the reg_addr_t (5-bit) and xlen_t typedefs;
  - the ZERO_REG constant;
  - the arb_state_e enum {ARB_NORMAL, ARB_MDU_FORCE}.
- One sub-module is natural: regfile_scoreboard. It holds the 32-bit pending vector with set/clear ports and the three read lookups.

Test Plan:
- Reset, then WB writes rd=5, data=0xDEADBEEF with pipe_wb_valid=1 -> next cycle: reg_write=1, wb_rd_addr=5, back_rd_data=0xDEADBEEF. No write occurs during or after a reset cycle.
- WB and MDU both valid in one cycle (WB rd=3, MDU rd=7) -> WB written first. MDU is written the cycle after the WB bubble (pipe_wb_valid=0).
- Long issue to rd=9, then issue of an instruction with rs1=9 -> issue_stall=1 until the cycle after the MDU result for rd=9 is accepted. issue_stall drops to 0 in that acceptance cycle's successor.
- Long issue to rd=0, then an MDU result for rd=0 -> pending never set, no stall, and reg_write stays 0.
- With WB_STARVE_GUARD_EN and STARVE_MAX=4: WB is held valid continuously while the MDU is valid -> pipe_wb_ready=0 on cycle 5, MDU accepted, state returns to ARB_NORMAL. Without the macro, the MDU stays blocked.
- Reset asserted while pending[12]=1 and the MDU is valid -> scoreboard cleared and outputs 0 on the next cycle.

Source files
------------

// File: rtl/regfile_wb_sched_pkg.sv
// Shared types for the register-file write-port scheduler.
// Address/data typedefs, the x0 constant and the arbitration state enum.
package regfile_wb_sched_pkg;

   localparam int XLEN_DEF = 32;

   typedef logic [4:0]          reg_addr_t;
   typedef logic [XLEN_DEF-1:0] xlen_t;

   localparam reg_addr_t ZERO_REG = 5'd0;

   typedef enum logic [0:0] {
      ARB_NORMAL    = 1'b0,
      ARB_MDU_FORCE = 1'b1
   } arb_state_e;

endpackage

// File: rtl/regfile_wb_sched_scoreboard.sv
// Pending-destination scoreboard for outstanding MDU results.
// One set port, one clear port, three combinational lookups.
module regfile_scoreboard
   import regfile_wb_sched_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        set_en,
   input  reg_addr_t   set_addr,
   input  logic        clr_en,
   input  reg_addr_t   clr_addr,
   input  reg_addr_t   rd_addr_a,
   input  reg_addr_t   rd_addr_b,
   input  reg_addr_t   rd_addr_c,
   output logic        hit_a,
   output logic        hit_b,
   output logic        hit_c,
   output logic [31:0] pending_o
);

   logic [31:0] pending_q;
   logic [31:0] pending_d;

   // Clear is applied first so a same-cycle set of the same register wins.
   always_comb begin
      pending_d = pending_q;
      if (clr_en) begin
         pending_d[clr_addr] = 1'b0;
      end
      if (set_en) begin
         pending_d[set_addr] = 1'b1;
      end
      pending_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign hit_a     = pending_q[rd_addr_a];
   assign hit_b     = pending_q[rd_addr_b];
   assign hit_c     = pending_q[rd_addr_c];
   assign pending_o = pending_q;

endmodule

// File: rtl/regfile_wb_sched.sv
// Register-file write-port scheduler between WB and the MDU, with hazard stall.
// Optional MDU starvation guard enabled by defining WB_STARVE_GUARD_EN.
module regfile_wb_sched
   import regfile_wb_sched_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int XLEN       = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pipe_wb_valid,
   output logic            pipe_wb_ready,
   input  reg_addr_t       pipe_wb_rd,
   input  logic [XLEN-1:0] pipe_wb_data,
   input  logic            mdu_valid,
   output logic            mdu_ready,
   input  reg_addr_t       mdu_rd,
   input  logic [XLEN-1:0] mdu_data,
   input  logic            issue_valid,
   input  logic            issue_long,
   input  reg_addr_t       issue_rs1,
   input  reg_addr_t       issue_rs2,
   input  reg_addr_t       issue_rd,
   output logic            issue_stall,
   output logic            reg_write,
   output reg_addr_t       wb_rd_addr,
   output logic [XLEN-1:0] back_rd_data
);

   logic            wb_acc;
   logic            mdu_acc;
   logic            set_en;
   logic            hit_rs1;
   logic            hit_rs2;
   logic            hit_rd;
   logic [31:0]     pending;

   logic            reg_write_q;
   logic            reg_write_d;
   reg_addr_t       wb_rd_addr_q;
   reg_addr_t       wb_rd_addr_d;
   logic [XLEN-1:0] back_rd_data_q;
   logic [XLEN-1:0] back_rd_data_d;

`ifdef WB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   arb_state_e      state_q;
   arb_state_e      state_d;
   logic [CNT_W-1:0] starve_q;
   logic [CNT_W-1:0] starve_d;

   always_comb begin
      pipe_wb_ready = 1'b1;
      mdu_ready     = !pipe_wb_valid;
      unique case (state_q)
         ARB_MDU_FORCE: begin
            pipe_wb_ready = 1'b0;
            mdu_ready     = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // The force state is entered the cycle after the STARVE_MAX-th loss.
   always_comb begin
      starve_d = starve_q;
      state_d  = state_q;
      if (mdu_acc) begin
         starve_d = '0;
         state_d  = ARB_NORMAL;
      end else if (mdu_valid) begin
         if (starve_q != CNT_W'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
         end
         if (starve_d == CNT_W'(STARVE_MAX)) begin
            state_d = ARB_MDU_FORCE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ARB_NORMAL;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end
`else
   always_comb begin
      pipe_wb_ready = 1'b1;
      mdu_ready     = !pipe_wb_valid;
   end
`endif

   assign wb_acc  = pipe_wb_valid && pipe_wb_ready;
   assign mdu_acc = mdu_valid && mdu_ready && !wb_acc;

   assign issue_stall = issue_valid && (hit_rs1 || hit_rs2 || hit_rd);
   assign set_en      = issue_valid && issue_long && !issue_stall &&
                        (issue_rd != ZERO_REG);

   regfile_scoreboard u_sb (
      .clk       (clk),
      .rst       (rst),
      .set_en    (set_en),
      .set_addr  (issue_rd),
      .clr_en    (mdu_acc),
      .clr_addr  (mdu_rd),
      .rd_addr_a (issue_rs1),
      .rd_addr_b (issue_rs2),
      .rd_addr_c (issue_rd),
      .hit_a     (hit_rs1),
      .hit_b     (hit_rs2),
      .hit_c     (hit_rd),
      .pending_o (pending)
   );

   // x0 destinations complete the handshake but never enable the write.
   always_comb begin
      reg_write_d    = 1'b0;
      wb_rd_addr_d   = wb_rd_addr_q;
      back_rd_data_d = back_rd_data_q;
      if (wb_acc) begin
         reg_write_d    = (pipe_wb_rd != ZERO_REG);
         wb_rd_addr_d   = pipe_wb_rd;
         back_rd_data_d = pipe_wb_data;
      end else if (mdu_acc) begin
         reg_write_d    = (mdu_rd != ZERO_REG);
         wb_rd_addr_d   = mdu_rd;
         back_rd_data_d = mdu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write_q    <= 1'b0;
         wb_rd_addr_q   <= ZERO_REG;
         back_rd_data_q <= '0;
      end else begin
         reg_write_q    <= reg_write_d;
         wb_rd_addr_q   <= wb_rd_addr_d;
         back_rd_data_q <= back_rd_data_d;
      end
   end

   assign reg_write    = reg_write_q;
   assign wb_rd_addr   = wb_rd_addr_q;
   assign back_rd_data = back_rd_data_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         a_no_wb_waw: assert (!(wb_acc && (pipe_wb_rd != ZERO_REG) &&
                                pending[pipe_wb_rd]));
         a_mdu_pend: assert (!(mdu_acc && (mdu_rd != ZERO_REG) &&
                               !pending[mdu_rd]));
      end
   end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed cases plus randomized traffic
// checked every cycle against a behavioural model of arbitration and hazards.
module tb_regfile_wb_sched;
   import regfile_wb_sched_pkg::*;

   localparam int STARVE_MAX = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        pipe_wb_valid = 1'b0;
   logic        pipe_wb_ready;
   logic [4:0]  pipe_wb_rd = '0;
   logic [31:0] pipe_wb_data = '0;
   logic        mdu_valid = 1'b0;
   logic        mdu_ready;
   logic [4:0]  mdu_rd = '0;
   logic [31:0] mdu_data = '0;
   logic        issue_valid = 1'b0;
   logic        issue_long = 1'b0;
   logic [4:0]  issue_rs1 = '0;
   logic [4:0]  issue_rs2 = '0;
   logic [4:0]  issue_rd = '0;
   logic        issue_stall;
   logic        reg_write;
   logic [4:0]  wb_rd_addr;
   logic [31:0] back_rd_data;

   regfile_wb_sched #(.STARVE_MAX(STARVE_MAX), .XLEN(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .pipe_wb_valid (pipe_wb_valid),
      .pipe_wb_ready (pipe_wb_ready),
      .pipe_wb_rd    (pipe_wb_rd),
      .pipe_wb_data  (pipe_wb_data),
      .mdu_valid     (mdu_valid),
      .mdu_ready     (mdu_ready),
      .mdu_rd        (mdu_rd),
      .mdu_data      (mdu_data),
      .issue_valid   (issue_valid),
      .issue_long    (issue_long),
      .issue_rs1     (issue_rs1),
      .issue_rs2     (issue_rs2),
      .issue_rd      (issue_rd),
      .issue_stall   (issue_stall),
      .reg_write     (reg_write),
      .wb_rd_addr    (wb_rd_addr),
      .back_rd_data  (back_rd_data)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: which registers await an MDU result, how long the MDU has lost.
   bit          m_pend [32];
   int          m_blocked;
   bit          m_force;
   bit          exp_we;
   logic [4:0]  exp_addr;
   logic [31:0] exp_data;
   bit          last_wb_acc;
   bit          last_mdu_acc;
   bit          last_set;
   logic [4:0]  mdu_q [$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   task automatic model_clear();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_blocked    = 0;
      m_force      = 1'b0;
      exp_we       = 1'b0;
      last_wb_acc  = 1'b0;
      last_mdu_acc = 1'b0;
      last_set     = 1'b0;
      mdu_q.delete();
   endtask

   task automatic idle();
      pipe_wb_valid = 1'b0;
      mdu_valid     = 1'b0;
      issue_valid   = 1'b0;
      issue_long    = 1'b0;
      issue_rs1     = '0;
      issue_rs2     = '0;
      issue_rd      = '0;
   endtask

   // One clock: check combinational outputs, advance model, check write port.
   task automatic step();
      bit stall;
      bit wbr;
      bit mr;
      #1;
      stall = issue_valid &&
              (m_pend[issue_rs1] || m_pend[issue_rs2] || m_pend[issue_rd]);
      wbr = !m_force;
      mr  = m_force || !pipe_wb_valid;
      chk("pipe_wb_ready", 32'(pipe_wb_ready), 32'(wbr));
      chk("mdu_ready", 32'(mdu_ready), 32'(mr));
      chk("issue_stall", 32'(issue_stall), 32'(stall));
      last_wb_acc  = pipe_wb_valid && wbr;
      last_mdu_acc = mdu_valid && mr && !last_wb_acc;
      exp_we = 1'b0;
      if (last_wb_acc) begin
         exp_we   = (pipe_wb_rd != 5'd0);
         exp_addr = pipe_wb_rd;
         exp_data = pipe_wb_data;
      end else if (last_mdu_acc) begin
         exp_we   = (mdu_rd != 5'd0);
         exp_addr = mdu_rd;
         exp_data = mdu_data;
      end
      last_set = issue_valid && issue_long && !stall && (issue_rd != 5'd0);
      if (last_mdu_acc) m_pend[mdu_rd] = 1'b0;
      if (last_set) m_pend[issue_rd] = 1'b1;
`ifdef WB_STARVE_GUARD_EN
      if (last_mdu_acc) begin
         m_blocked = 0;
         m_force   = 1'b0;
      end else if (mdu_valid) begin
         m_blocked++;
         if (m_blocked >= STARVE_MAX) m_force = 1'b1;
      end
`endif
      @(posedge clk);
      #1;
      chk("reg_write", 32'(reg_write), 32'(exp_we));
      if (exp_we) begin
         chk("wb_rd_addr", 32'(wb_rd_addr), 32'(exp_addr));
         chk("back_rd_data", back_rd_data, exp_data);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_reg_write", 32'(reg_write), 32'd0);
      chk("rst_wb_rd_addr", 32'(wb_rd_addr), 32'd0);
      chk("rst_back_rd_data", back_rd_data, 32'd0);
      chk("rst_issue_stall", 32'(issue_stall), 32'd0);
      model_clear();
      rst = 1'b0;
      idle();
   endtask

   int acc_cyc;

   initial begin
      model_clear();
      // Reset with a WB result offered: nothing may be written.
      pipe_wb_valid = 1'b1;
      pipe_wb_rd    = 5'd5;
      pipe_wb_data  = 32'h1234_5678;
      do_reset();

      // Plain WB write, one cycle latency.
      pipe_wb_valid = 1'b1;
      pipe_wb_rd    = 5'd5;
      pipe_wb_data  = 32'hDEAD_BEEF;
      step();
      chk("t1_we", 32'(reg_write), 32'd1);
      chk("t1_addr", 32'(wb_rd_addr), 32'd5);
      chk("t1_data", back_rd_data, 32'hDEAD_BEEF);
      idle();

      // WB and MDU collide: WB first, MDU on the bubble.
      issue_valid = 1'b1;
      issue_long  = 1'b1;
      issue_rd    = 5'd7;
      issue_rs1   = 5'd1;
      issue_rs2   = 5'd2;
      step();
      idle();
      pipe_wb_valid = 1'b1;
      pipe_wb_rd    = 5'd3;
      pipe_wb_data  = 32'h0000_0033;
      mdu_valid     = 1'b1;
      mdu_rd        = 5'd7;
      mdu_data      = 32'h0000_0077;
      step();
      chk("t2_wb_addr", 32'(wb_rd_addr), 32'd3);
      chk("t2_wb_data", back_rd_data, 32'h0000_0033);
      pipe_wb_valid = 1'b0;
      step();
      chk("t2_mdu_we", 32'(reg_write), 32'd1);
      chk("t2_mdu_addr", 32'(wb_rd_addr), 32'd7);
      chk("t2_mdu_data", back_rd_data, 32'h0000_0077);
      idle();

      // RAW on a pending MDU destination.
      issue_valid = 1'b1;
      issue_long  = 1'b1;
      issue_rd    = 5'd9;
      step();
      issue_long = 1'b0;
      issue_rd   = 5'd1;
      issue_rs1  = 5'd9;
      step();
      chk("t3_stall_a", 32'(issue_stall), 32'd1);
      step();
      mdu_valid = 1'b1;
      mdu_rd    = 5'd9;
      mdu_data  = 32'h9999_0009;
      #1;
      chk("t3_stall_acc", 32'(issue_stall), 32'd1);
      step();
      mdu_valid = 1'b0;
      chk("t3_stall_drop", 32'(issue_stall), 32'd0);
      chk("t3_mdu_addr", 32'(wb_rd_addr), 32'd9);
      idle();

      // Long issue and MDU result for x0.
      issue_valid = 1'b1;
      issue_long  = 1'b1;
      issue_rd    = 5'd0;
      step();
      issue_long = 1'b0;
      mdu_valid  = 1'b1;
      mdu_rd     = 5'd0;
      mdu_data   = 32'hFFFF_FFFF;
      step();
      chk("t4_we", 32'(reg_write), 32'd0);
      chk("t4_stall", 32'(issue_stall), 32'd0);
      idle();
      step();

      // WB held valid against a waiting MDU result.
      issue_valid = 1'b1;
      issue_long  = 1'b1;
      issue_rd    = 5'd11;
      step();
      idle();
      mdu_valid     = 1'b1;
      mdu_rd        = 5'd11;
      mdu_data      = 32'hB0B0_0011;
      pipe_wb_valid = 1'b1;
      pipe_wb_rd    = 5'd16;
      pipe_wb_data  = 32'h0;
      acc_cyc = -1;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (last_mdu_acc && acc_cyc < 0) acc_cyc = c;
         if (last_mdu_acc) mdu_valid = 1'b0;
         if (last_wb_acc) begin
            pipe_wb_rd   = 5'(16 + c);
            pipe_wb_data = 32'(c);
         end
      end
`ifdef WB_STARVE_GUARD_EN
      chk("t5_force_cycle", 32'(acc_cyc), 32'd5);
`else
      chk("t5_blocked", 32'(acc_cyc), 32'hFFFF_FFFF);
`endif
      pipe_wb_valid = 1'b0;
      for (int c = 0; c < 4 && mdu_valid; c++) begin
         step();
         if (last_mdu_acc) mdu_valid = 1'b0;
      end
      chk("t5_drained", 32'(mdu_valid), 32'd0);
      idle();
      step();

      // Reset mid-operation with pending[12] and MDU waiting.
      issue_valid = 1'b1;
      issue_long  = 1'b1;
      issue_rd    = 5'd12;
      step();
      idle();
      mdu_valid     = 1'b1;
      mdu_rd        = 5'd12;
      mdu_data      = 32'hC0DE_0012;
      pipe_wb_valid = 1'b1;
      pipe_wb_rd    = 5'd20;
      pipe_wb_data  = 32'h0000_00AA;
      step();
      do_reset();
      issue_valid = 1'b1;
      issue_rs1   = 5'd12;
      issue_rd    = 5'd1;
      #1;
      chk("t6_sb_cleared", 32'(issue_stall), 32'd0);
      step();
      do_reset();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if (last_set) mdu_q.push_back(issue_rd);
         if (last_wb_acc) pipe_wb_valid = 1'b0;
         if (last_mdu_acc) mdu_valid = 1'b0;
         if (!pipe_wb_valid && $urandom_range(9) < 6) begin
            pipe_wb_valid = 1'b1;
            pipe_wb_rd    = ($urandom_range(7) == 0) ? 5'd0 :
                            5'(16 + $urandom_range(15));
            pipe_wb_data  = $urandom;
         end
         if (!mdu_valid) begin
            if (mdu_q.size() > 0 && $urandom_range(2) == 0) begin
               mdu_valid = 1'b1;
               mdu_rd    = mdu_q.pop_front();
               mdu_data  = $urandom;
            end else if (mdu_q.size() == 0 && $urandom_range(19) == 0) begin
               mdu_valid = 1'b1;
               mdu_rd    = 5'd0;
               mdu_data  = $urandom;
            end
         end
         issue_valid = ($urandom_range(3) != 0);
         issue_long  = ($urandom_range(2) == 0);
         issue_rs1   = 5'($urandom_range(31));
         issue_rs2   = 5'($urandom_range(31));
         issue_rd    = issue_long ? 5'($urandom_range(15)) :
                                    5'($urandom_range(31));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
